// File: rtl/vram_cpu_access.sv
// CPU-side VRAM port of the LSPC.
// Holds the VRAMADDR/VRAMMOD registers and the write-data latch. It turns CPU register
// strobes into write/read requests for the slow (lower) and fast (upper) VRAM cycle
// blocks, applies the post-write auto-increment, and captures read data into the
// VRAMRW read buffer.
// Ports:
//   CLK_24M, RESETP                   clock, synchronous active-high reset
//   CPU_DATA, WR_VRAMADDR/RW/MOD      CPU write data and 1-clk register strobes
//   LOW_/HIGH_WR_ACK, LOW_/HIGH_RD_ACK  cycle-block acks (selected by REG_VRAMADDR_MSB)
//   VRAM_LOW_READ, VRAM_HIGH_READ     read data buses from the cycle blocks
//   VRAM_ADDR, REG_VRAMADDR_MSB       address and half select to the cycle blocks
//   VRAM_WRITE                        write-data latch
//   nVRAM_WRITE_REQ, nVRAM_READ_REQ   active-low requests
//   CPU_READ_DATA, REG_VRAMMOD        VRAMRW read buffer and modulo readback
//   BUSY, OVERRUN                     request outstanding / sticky lost-strobe flag
module vram_cpu_access #(
    parameter bit PREFETCH = 1'b1,
    parameter bit QUEUE_EN = 1'b1
) (
    input  logic        CLK_24M,
    input  logic        RESETP,
    input  logic [15:0] CPU_DATA,
    input  logic        WR_VRAMADDR,
    input  logic        WR_VRAMRW,
    input  logic        WR_VRAMMOD,
    input  logic        LOW_WR_ACK,
    input  logic        HIGH_WR_ACK,
    input  logic        LOW_RD_ACK,
    input  logic        HIGH_RD_ACK,
    input  logic [15:0] VRAM_LOW_READ,
    input  logic [15:0] VRAM_HIGH_READ,
    output logic [14:0] VRAM_ADDR,
    output logic        REG_VRAMADDR_MSB,
    output logic [15:0] VRAM_WRITE,
    output logic        nVRAM_WRITE_REQ,
    output logic        nVRAM_READ_REQ,
    output logic [15:0] CPU_READ_DATA,
    output logic [15:0] REG_VRAMMOD,
    output logic        BUSY,
    output logic        OVERRUN
);

    typedef enum logic [1:0] {StIdle, StWritePend, StReadPend} state_e;

    state_e      state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic        msb_q, msb_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] mod_q, mod_d;
    logic        overrun_q, overrun_d;
    logic        slot_valid_q, slot_valid_d;
    logic        slot_rw_q, slot_rw_d;       // 1 = VRAMRW, 0 = VRAMADDR
    logic [15:0] slot_data_q, slot_data_d;

    logic        wr_ack, rd_ack, free;
    logic        exec_valid, exec_rw;
    logic [15:0] exec_data;

    // State register
    always_ff @(posedge CLK_24M) begin
        if (RESETP) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            msb_q        <= 1'b0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mod_q        <= '0;
            overrun_q    <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_rw_q    <= 1'b0;
            slot_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            msb_q        <= msb_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            mod_q        <= mod_d;
            overrun_q    <= overrun_d;
            slot_valid_q <= slot_valid_d;
            slot_rw_q    <= slot_rw_d;
            slot_data_q  <= slot_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        msb_d        = msb_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        overrun_d    = overrun_q;
        slot_valid_d = slot_valid_q;
        slot_rw_d    = slot_rw_q;
        slot_data_d  = slot_data_q;
        exec_valid   = 1'b0;
        exec_rw      = 1'b0;
        exec_data    = '0;
        free         = 1'b0;

        wr_ack = msb_q ? HIGH_WR_ACK : LOW_WR_ACK;
        rd_ack = msb_q ? HIGH_RD_ACK : LOW_RD_ACK;
        // A modulo write on the same edge as an ack feeds the increment directly.
        mod_d  = WR_VRAMMOD ? CPU_DATA : mod_q;

        unique case (state_q)
            StIdle: free = 1'b1;
            StWritePend: begin
                if (wr_ack) begin
                    addr_d = addr_q + mod_d[14:0];
                    if (PREFETCH) begin
                        state_d = StReadPend;
                    end else begin
                        state_d = StIdle;
                        free    = 1'b1;
                    end
                end
            end
            StReadPend: begin
                if (rd_ack) begin
                    rdata_d = msb_q ? VRAM_HIGH_READ : VRAM_LOW_READ;
                    state_d = StIdle;
                    free    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Command arbitration: the held slot goes first, then VRAMADDR, then VRAMRW.
        // Only one command starts per edge; the rest are held or dropped.
        if (free && slot_valid_q) begin
            exec_valid   = 1'b1;
            exec_rw      = slot_rw_q;
            exec_data    = slot_data_q;
            slot_valid_d = 1'b0;
        end
        if (WR_VRAMADDR) begin
            if (free && !exec_valid) begin
                exec_valid = 1'b1;
                exec_rw    = 1'b0;
                exec_data  = CPU_DATA;
            end else if (QUEUE_EN && !slot_valid_d) begin
                slot_valid_d = 1'b1;
                slot_rw_d    = 1'b0;
                slot_data_d  = CPU_DATA;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (WR_VRAMRW) begin
            if (free && !exec_valid) begin
                exec_valid = 1'b1;
                exec_rw    = 1'b1;
                exec_data  = CPU_DATA;
            end else if (QUEUE_EN && !slot_valid_d) begin
                slot_valid_d = 1'b1;
                slot_rw_d    = 1'b1;
                slot_data_d  = CPU_DATA;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (exec_valid) begin
            if (exec_rw) begin
                wdata_d = exec_data;
                state_d = StWritePend;
            end else begin
                {msb_d, addr_d} = exec_data;
                state_d         = PREFETCH ? StReadPend : StIdle;
            end
        end
    end

    // Outputs: requests decode straight from state, so they can never both be low.
    always_comb begin
        VRAM_ADDR        = addr_q;
        REG_VRAMADDR_MSB = msb_q;
        VRAM_WRITE       = wdata_q;
        nVRAM_WRITE_REQ  = (state_q != StWritePend);
        nVRAM_READ_REQ   = (state_q != StReadPend);
        CPU_READ_DATA    = rdata_q;
        REG_VRAMMOD      = mod_q;
        BUSY             = (state_q != StIdle);
        OVERRUN          = overrun_q;
    end

endmodule
